imem_fetch_resp: RTL and testbench

Instruction-memory responder that serves the fetch requests issued by the program counter stage. It accepts word-addressed PCs over a valid/ready handshake, reads a synchronous instruction RAM through a fixed-latency pipeline, and buffers the results in a small response FIFO that drains to decode. Credit-based flow control guarantees that no in-flight read is ever dropped for lack of space. A flush input discards all in-flight and buffered responses on a PC redirect.

---
 rtl/imem_fetch_resp_if.sv | 30 +++
 rtl/imem_fetch_resp.sv | 181 ++++++++++++++++++
 tb/tb_imem_fetch_resp.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_resp_if.sv
// Fetch-response bus: PC request handshake, redirect flush, response
// handshake toward decode, and the program-load write port.
//   master: drives req_valid/req_pc/flush/rsp_ready/wr_*; observes the rest
//   slave : the responder; drives req_ready and rsp_*
interface imem_fetch_resp_if #(
    parameter int unsigned DEPTH_LOG2 = 10
);
    logic                  req_valid;
    logic [31:0]           req_pc;
    logic                  req_ready;
    logic                  flush;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_pc;
    logic [31:0]           rsp_inst;
    logic                  rsp_fault;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [31:0]           wr_data;

    modport master (
        output req_valid, req_pc, flush, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_pc, rsp_inst, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, flush, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_pc, rsp_inst, rsp_fault
    );
endinterface

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder for the fetch stage.
// Accepts word-addressed PCs, reads a synchronous RAM through a LATENCY-deep
// non-stalling pipeline and buffers results in a FIFO_DEPTH response FIFO.
// A credit counter over in-flight reads plus buffered entries keeps the FIFO
// from ever overflowing. flush drops all outstanding work.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (RAM contents kept)
//   bus  - imem_fetch_resp_if.slave (request, response and write port)
module imem_fetch_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    imem_fetch_resp_if.slave bus
);
    localparam int unsigned RAM_DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } rsp_t;

    logic [31:0]        mem [RAM_DEPTH];
    logic [31:0]        ram_q;
    logic [CW-1:0]      cnt;
    logic               req_ready;
    logic               accept;
    logic               pop;
    logic               push;
    logic               fault_in;

    logic [LATENCY-1:0] st_valid;
    logic [LATENCY-1:0] st_fault;
    logic [31:0]        st_pc [LATENCY];
    logic [31:0]        last_inst;
    rsp_t               push_ent;

    rsp_t               fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr_nxt;
    logic [PW-1:0]      rd_ptr_nxt;
    logic [AW-1:0]      head_idx;
    rsp_t               head_nxt;
    logic               valid_nxt;

    rsp_t               rsp_q;
    logic               rsp_valid_q;

    // Handshake qualifiers; push is suppressed on flush/reset so a read
    // completing in that cycle is discarded.
    assign req_ready = !rst && (cnt < CW'(FIFO_DEPTH));
    assign fault_in  = |bus.req_pc[31:DEPTH_LOG2];

    always_comb begin
        accept = bus.req_valid && req_ready && !bus.flush;
        pop    = rsp_valid_q && bus.rsp_ready;
        push   = st_valid[LATENCY-1] && !bus.flush && !rst;
    end

    // Credits: in-flight reads plus buffered responses.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !accept) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Synchronous RAM; read-before-write gives old data on a same-address
    // collision. Writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (accept) begin
            ram_q <= mem[bus.req_pc[DEPTH_LOG2-1:0]];
        end
    end

    // Pipeline control: valids reset, tags shift every cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            st_valid <= '0;
        end else begin
            st_valid[0] <= accept;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        st_pc[0]    <= bus.req_pc;
        st_fault[0] <= fault_in;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            st_pc[i]    <= st_pc[i-1];
            st_fault[i] <= st_fault[i-1];
        end
    end

    // RAM data is already one stage old when it leaves the RAM, so it only
    // needs LATENCY-1 further delay stages.
    if (LATENCY == 1) begin : g_inst_direct
        assign last_inst = ram_q;
    end else begin : g_inst_delay
        logic [31:0] inst_d [LATENCY-1];

        always_ff @(posedge clk) begin
            inst_d[0] <= ram_q;
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                inst_d[i] <= inst_d[i-1];
            end
        end

        assign last_inst = inst_d[LATENCY-2];
    end

    always_comb begin
        push_ent.pc    = st_pc[LATENCY-1];
        push_ent.fault = st_fault[LATENCY-1];
        push_ent.inst  = st_fault[LATENCY-1] ? NOP : last_inst;
    end

    // Next head of the FIFO, looking through a push that lands in the slot
    // that becomes the head (empty FIFO, or last entry being popped).
    always_comb begin
        wr_ptr_nxt = wr_ptr + PW'(push);
        rd_ptr_nxt = rd_ptr + PW'(pop);
        head_idx   = rd_ptr_nxt[AW-1:0];
        head_nxt   = fifo_mem[head_idx];
        if (push && (wr_ptr[AW-1:0] == head_idx)) begin
            head_nxt = push_ent;
        end
        valid_nxt  = (wr_ptr_nxt != rd_ptr_nxt);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_ent;
        end
    end

    // Pointers and registered head; head fields change only when a new
    // entry is presented, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            rsp_valid_q <= valid_nxt;
            if (valid_nxt) begin
                rsp_q <= head_nxt;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_pc    = rsp_q.pc;
    assign bus.rsp_inst  = rsp_q.inst;
    assign bus.rsp_fault = rsp_q.fault;
endmodule

// File: tb/tb_imem_fetch_resp.sv
// Testbench for imem_fetch_resp: directed scenarios plus randomized traffic
// against a queue-based reference model of the response stream.
module tb_imem_fetch_resp;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk;
    logic rst;

    imem_fetch_resp_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    imem_fetch_resp #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        int          vis;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } obs_t;

    ent_t        pend[$];
    obs_t        popped[$];
    logic [31:0] ram_m [1 << DEPTH_LOG2];
    int          cyc;
    bit          zero_q;
    int          n_checks;
    int          n_errors;
    int          dut_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance.
    task automatic step(input bit v, input logic [31:0] pc, input bit fl, input bit rr,
                        input bit we, input logic [DEPTH_LOG2-1:0] wa,
                        input logic [31:0] wd, input bit r);
        bit   ev;
        bit   acc;
        bit   pp;
        obs_t o;
        ent_t e;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_pc    = pc;
        bus.flush     = fl;
        bus.rsp_ready = rr;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        #1;
        ev = (pend.size() > 0) && (pend[0].vis <= cyc);
        chk("req_ready", 32'(bus.req_ready), 32'(!r && (pend.size() < FIFO_DEPTH)));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_pc", bus.rsp_pc, pend[0].pc);
            chk("rsp_inst", bus.rsp_inst, pend[0].inst);
            chk("rsp_fault", 32'(bus.rsp_fault), 32'(pend[0].fault));
            zero_q = 1'b0;
        end else if (zero_q) begin
            chk("rst_pc", bus.rsp_pc, 32'h0);
            chk("rst_inst", bus.rsp_inst, 32'h0);
            chk("rst_fault", 32'(bus.rsp_fault), 32'h0);
        end
        if (bus.req_ready && v && !fl) dut_acc++;
        acc = !r && !fl && v && (pend.size() < FIFO_DEPTH);
        pp  = !r && ev && rr;
        if (pp) begin
            o.pc    = bus.rsp_pc;
            o.inst  = bus.rsp_inst;
            o.fault = bus.rsp_fault;
            popped.push_back(o);
        end
        if (r || fl) begin
            pend.delete();
            if (r) zero_q = 1'b1;
        end else begin
            if (pp) void'(pend.pop_front());
            if (acc) begin
                e.pc    = pc;
                e.fault = (pc >> DEPTH_LOG2) != 0;
                e.inst  = e.fault ? NOP : ram_m[pc[DEPTH_LOG2-1:0]];
                e.vis   = cyc + LATENCY + 1;
                pend.push_back(e);
            end
        end
        if (!r && we) ram_m[wa] = wd;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, rr, 0, '0, 32'h0, 0);
    endtask

    task automatic req(input logic [31:0] pc, input bit rr);
        step(1, pc, 0, rr, 0, '0, 32'h0, 0);
    endtask

    initial begin
        int          base;
        logic [31:0] rpc;
        n_checks = 0;
        n_errors = 0;
        dut_acc  = 0;
        cyc      = 0;
        zero_q   = 1'b1;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        step(0, 32'h0, 0, 0, 0, '0, 32'h0, 1);
        step(0, 32'h0, 0, 0, 0, '0, 32'h0, 1);

        // Program load: known values at 0..7 and 0x20, random elsewhere.
        for (int a = 0; a < (1 << DEPTH_LOG2); a++) begin
            logic [31:0] d;
            d = $urandom;
            if (a < 8) d = 32'h100 + 32'(a);
            if (a == 32'h20) d = 32'hC0DE_0020;
            step(0, 32'h0, 0, 1, 1, DEPTH_LOG2'(a), d, 0);
        end

        // Streaming with rsp_ready high.
        idle(2, 1);
        popped.delete();
        for (int i = 0; i < 8; i++) req(32'(i), 1);
        idle(5, 1);
        chk("stream_count", 32'(popped.size()), 32'd8);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            chk("stream_inst", popped[i].inst, 32'h100 + 32'(i));

        // Backpressure: six offered, four taken.
        popped.delete();
        base = dut_acc;
        for (int i = 0; i < 6; i++) req(32'd10 + 32'(dut_acc - base), 0);
        chk("bp_accepts", 32'(dut_acc - base), 32'd4);
        chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
        idle(1, 1);
        idle(1, 0);
        chk("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
        idle(6, 1);
        chk("bp_count", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("bp_order", popped[i].pc, 32'd10 + 32'(i));

        // Range check boundary.
        popped.delete();
        req(32'h400, 1);
        req(32'h3FF, 1);
        idle(5, 1);
        chk("fault_count", 32'(popped.size()), 32'd2);
        if (popped.size() == 2) begin
            chk("fault_hi", 32'(popped[0].fault), 32'd1);
            chk("fault_nop", popped[0].inst, NOP);
            chk("fault_edge", 32'(popped[1].fault), 32'd0);
        end

        // Flush with two buffered, two in flight and a colliding request.
        popped.delete();
        for (int i = 0; i < 4; i++) req(32'(i), 0);
        step(1, 32'd9, 1, 0, 0, '0, 32'h0, 0);
        idle(1, 1);
        chk("flush_valid", 32'(bus.rsp_valid), 32'd0);
        req(32'h20, 1);
        idle(5, 1);
        chk("flush_count", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) begin
            chk("flush_pc", popped[0].pc, 32'h20);
            chk("flush_inst", popped[0].inst, 32'hC0DE_0020);
        end

        // Write/read collision returns old data first.
        popped.delete();
        step(1, 32'd5, 0, 1, 1, DEPTH_LOG2'(5), 32'hDEAD, 0);
        req(32'd5, 1);
        idle(5, 1);
        chk("wr_count", 32'(popped.size()), 32'd2);
        if (popped.size() == 2) begin
            chk("wr_old", popped[0].inst, 32'h105);
            chk("wr_new", popped[1].inst, 32'hDEAD);
        end
        step(0, 32'h0, 0, 1, 1, DEPTH_LOG2'(5), 32'h105, 0);

        // Reset with three buffered; coinciding write is dropped.
        popped.delete();
        for (int i = 0; i < 3; i++) req(32'(i), 0);
        idle(4, 0);
        step(0, 32'h0, 0, 0, 1, DEPTH_LOG2'(0), 32'hBAD, 1);
        idle(1, 0);
        chk("rst_out_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_out_pc", bus.rsp_pc, 32'h0);
        chk("rst_out_inst", bus.rsp_inst, 32'h0);
        req(32'd0, 1);
        idle(5, 1);
        chk("rst_count", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) chk("rst_ram_kept", popped[0].inst, 32'h100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit v, fl, rr, we, r;
            v  = ($urandom_range(0, 99) < 70);
            fl = ($urandom_range(0, 99) < 3);
            rr = ($urandom_range(0, 99) < 70);
            we = ($urandom_range(0, 99) < 10);
            r  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) rpc = $urandom;
            else rpc = 32'($urandom_range(0, 32'h40F));
            step(v, rpc, fl, rr, we, DEPTH_LOG2'($urandom), $urandom, r);
        end
        idle(8, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
